cg_vector_chunk_buffer: RTL

//  Ping-pong vector store for the CG solver (r, p or x vector), one instance per vector.

---
 rtl/cg_vector_chunk_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cg_vector_chunk_buffer.sv
// cg_vector_chunk_buffer
//   Ping-pong vector store for the CG solver (one instance per r, p or x vector).
//   The read bank streams the current-iteration vector to the ALU one chunk of
//   NO_OF_UNITS elements per rd_req pulse. The ALU's updated chunks are captured
//   into the other (write) bank. At iteration end, swap exchanges the two banks.
//
//   Optional feature macro: CG_VBUF_PREV_PORT_EN
//     When defined, rd_prev_data returns the write-bank chunk at the read pointer
//     (the previous iteration's chunk), updated together with rd_data.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   total        vector length in elements (multiple of NO_OF_UNITS)
//   rd_req       pulse: fetch the next chunk from the read bank
//   rd_rewind    restart the read pointer at chunk 0
//   rd_data      chunk read, element 0 in the LSBs; holds its value when rd_valid=0
//   rd_valid     rd_data valid (one cycle per accepted rd_req)
//   rd_done      all N chunks read since the last swap/rewind
//   wr_en        store wr_data at the write pointer of the write bank
//   wr_data      updated chunk from the ALU
//   wr_done      N chunks written since the last swap
//   swap         iteration end: exchange banks (accepted only when wr_done)
//   running      FSM is in RUN
//   err          sticky {swap_err, wr_overflow}
//   rd_prev_data (CG_VBUF_PREV_PORT_EN only) write-bank chunk at the read pointer
module cg_vector_chunk_buffer #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int MEMORY_HEIGHT = 1000,
    parameter int ADDR_WIDTH    = $clog2(MEMORY_HEIGHT) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [31:0]                          total,
    input  logic                                 rd_req,
    input  logic                                 rd_rewind,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data,
    output logic                                 rd_valid,
    output logic                                 rd_done,
    input  logic                                 wr_en,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
    output logic                                 wr_done,
    input  logic                                 swap,
    output logic                                 running,
    output logic [1:0]                           err
`ifdef CG_VBUF_PREV_PORT_EN
    ,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_prev_data
`endif
);

    localparam int DW = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam int IW = $clog2(MEMORY_HEIGHT);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_next;
    logic                  bank_sel;
    logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr, n_chunks, n_calc;
    logic [31:0]           n_quot;
    logic                  swap_ok, swap_bad, rd_fire, wr_fire, wr_ovf;

    logic [DW-1:0] mem [2][MEMORY_HEIGHT];

    // An out-of-range length is folded to zero chunks, which makes both done
    // flags true immediately and blocks every array access.
    always_comb begin
        n_quot = total / 32'(NO_OF_UNITS);
        if (n_quot == 32'd0 || n_quot > 32'(MEMORY_HEIGHT))
            n_calc = '0;
        else
            n_calc = n_quot[ADDR_WIDTH-1:0];
    end

    assign rd_done = (rd_ptr == n_chunks);
    assign wr_done = (wr_ptr == n_chunks);
    assign running = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset)
            state <= INIT;
        else
            state <= state_next;
    end

    // Accepted swap masks rd_req/wr_en for the cycle; rewind masks rd_req.
    always_comb begin
        state_next = state;
        swap_ok    = 1'b0;
        swap_bad   = 1'b0;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        wr_ovf     = 1'b0;
        if (!reset) begin
            if (swap && wr_done) begin
                swap_ok    = 1'b1;
                state_next = RUN;
            end else begin
                swap_bad = swap;
                rd_fire  = (state == RUN) && rd_req && !rd_rewind && (rd_ptr < n_chunks);
                wr_fire  = wr_en && (wr_ptr < n_chunks);
                wr_ovf   = wr_en && !(wr_ptr < n_chunks);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[~bank_sel][wr_ptr[IW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            n_chunks <= n_calc;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= '0;
        end else begin
            rd_valid <= rd_fire;
            err      <= err | {swap_bad, wr_ovf};
            if (swap_ok) begin
                bank_sel <= ~bank_sel;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                n_chunks <= n_calc;
            end else begin
                if (rd_rewind)
                    rd_ptr <= '0;
                else if (rd_fire)
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                if (wr_fire)
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_fire)
                rd_data <= mem[bank_sel][rd_ptr[IW-1:0]];
        end
    end

`ifdef CG_VBUF_PREV_PORT_EN
    // Read-before-write: a same-cycle write to this entry is not yet visible.
    always_ff @(posedge clk) begin
        if (reset)
            rd_prev_data <= '0;
        else if (rd_fire)
            rd_prev_data <= mem[~bank_sel][rd_ptr[IW-1:0]];
    end
`endif

endmodule
